// File: rtl/vga_scandoubler.sv
// ----------------------------------------------------------------------------
// vga_scandoubler
//
// Converts the 15 kHz PAL stream from the sync generator into either a
// registered PAL passthrough or a line-doubled 31 kHz VGA-compatible stream.
// Each input line is written into one bank of a ping-pong line buffer at the
// pixel rate (ce_pixel), while the other bank, which holds the previously
// completed line, is read back twice at the full clk rate.
//
// Ports
//   clk                  system clock, 2x PAL pixel rate
//   rst_n                asynchronous active-low reset
//   ce_pixel             PAL pixel strobe (one clk in two)
//   enable_scandoubling  1: VGA output, 0: PAL passthrough
//   scanlines_enable     1: dim the second repeat of each doubled line
//   ri, gi, bi           PAL pixel colour, 3 bits each
//   hsync_ext_n          PAL hsync, active low
//   vsync_ext_n          PAL vsync, active low
//   ro, go, bo           output colour, 3 bits each
//   hsync, vsync         output syncs, active low
// ----------------------------------------------------------------------------
module vga_scandoubler #(
  parameter int LINE_DEPTH  = 512,
  parameter int HSYNC_WIDTH = 56
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce_pixel,
  input  logic       enable_scandoubling,
  input  logic       scanlines_enable,
  input  logic [2:0] ri,
  input  logic [2:0] gi,
  input  logic [2:0] bi,
  input  logic       hsync_ext_n,
  input  logic       vsync_ext_n,
  output logic [2:0] ro,
  output logic [2:0] go,
  output logic [2:0] bo,
  output logic       hsync,
  output logic       vsync
);

  localparam int                DATA_W   = 9;
  localparam int                ADDR_W   = $clog2(LINE_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(LINE_DEPTH - 1);
  localparam logic [ADDR_W-1:0] LEN_RST  = ADDR_W'(447);
  localparam logic [ADDR_W:0]   HS_LIM   = (ADDR_W + 1)'(HSYNC_WIDTH);

  // Write counter holds at the last entry instead of wrapping, so an
  // overlong line keeps overwriting the final slot.
  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
    return (v == ADDR_MAX) ? v : v + ADDR_W'(1);
  endfunction

  // Scanline dimming: halve the component.
  function automatic logic [2:0] dim_comp(input logic [2:0] c);
    return {1'b0, c[2:1]};
  endfunction

  // Control state
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              wbank_q, wbank_d;
  logic              half_q, half_d;
  logic              hs_prev_q, hs_prev_d;
  // Set once a complete line has been captured; gates the VGA output so no
  // hsync appears before the first input hsync falling edge.
  logic              vld_p0_q, vld_p0_d;

  logic [ADDR_W-1:0] rcnt_p1_q, rcnt_p1_d;
  logic              half_p1_q, half_p1_d;
  logic              rsel_p1_q, rsel_p1_d;
  logic              vld_p1_q, vld_p1_d;

  logic [DATA_W-1:0] rgb_p2_q, rgb_p2_d;
  logic              hsync_p2_q, hsync_p2_d;
  logic              vsync_p2_q, vsync_p2_d;

  // Line buffer storage (no reset so it maps onto block RAM)
  logic [DATA_W-1:0] bank0_mem [LINE_DEPTH];
  logic [DATA_W-1:0] bank1_mem [LINE_DEPTH];
  logic [DATA_W-1:0] rd0_p1_q;
  logic [DATA_W-1:0] rd1_p1_q;

  logic [DATA_W-1:0] pix_in;
  logic              hs_fall;

  assign pix_in  = {ri, gi, bi};
  assign hs_fall = ce_pixel & hs_prev_q & ~hsync_ext_n;

  // ---- stage p0: write side (pixel rate) and read address (clk rate) ----
  always_comb begin
    wcnt_d    = wcnt_q;
    wbank_d   = wbank_q;
    len_d     = len_q;
    hs_prev_d = hs_prev_q;
    vld_p0_d  = vld_p0_q;
    if (ce_pixel) begin
      hs_prev_d = hsync_ext_n;
      if (hs_fall) begin
        len_d    = wcnt_q;
        wcnt_d   = '0;
        wbank_d  = ~wbank_q;
        vld_p0_d = 1'b1;
      end else begin
        wcnt_d = sat_inc(wcnt_q);
      end
    end
  end

  // Resync to the input line start wins over the end-of-repeat wrap.
  always_comb begin
    rcnt_d = rcnt_q + ADDR_W'(1);
    half_d = half_q;
    if (hs_fall) begin
      rcnt_d = '0;
      half_d = 1'b0;
    end else if (rcnt_q == len_q) begin
      rcnt_d = '0;
      half_d = ~half_q;
    end
  end

  // The bank being written receives the current pixel at the old address
  // even on the hsync edge; the other bank is read every clk.
  always_ff @(posedge clk) begin
    if (ce_pixel && !wbank_q) bank0_mem[wcnt_q] <= pix_in;
    rd0_p1_q <= bank0_mem[rcnt_q];
  end

  always_ff @(posedge clk) begin
    if (ce_pixel && wbank_q) bank1_mem[wcnt_q] <= pix_in;
    rd1_p1_q <= bank1_mem[rcnt_q];
  end

  // ---- stage p1: RAM data valid, qualifiers delayed to match ----
  always_comb begin
    rcnt_p1_d = rcnt_q;
    half_p1_d = half_q;
    rsel_p1_d = ~wbank_q;
    vld_p1_d  = vld_p0_q;
  end

  // ---- stage p2: blanking, scanlines, mode select, output registers ----
  logic [DATA_W-1:0] rd_pix;
  logic [DATA_W-1:0] vga_pix;
  logic              in_hs;

  always_comb begin
    rd_pix  = rsel_p1_q ? rd1_p1_q : rd0_p1_q;
    in_hs   = ({1'b0, rcnt_p1_q} < HS_LIM);
    vga_pix = (vld_p1_q && !in_hs) ? rd_pix : '0;
    if (scanlines_enable && half_p1_q) begin
      vga_pix = {dim_comp(vga_pix[8:6]), dim_comp(vga_pix[5:3]), dim_comp(vga_pix[2:0])};
    end

    rgb_p2_d   = pix_in;
    hsync_p2_d = hsync_ext_n;
    vsync_p2_d = vsync_ext_n;
    if (enable_scandoubling) begin
      rgb_p2_d   = vga_pix;
      hsync_p2_d = ~(vld_p1_q & in_hs);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      len_q      <= LEN_RST;
      wbank_q    <= 1'b0;
      half_q     <= 1'b0;
      hs_prev_q  <= 1'b1;
      vld_p0_q   <= 1'b0;
      rcnt_p1_q  <= '0;
      half_p1_q  <= 1'b0;
      rsel_p1_q  <= 1'b1;
      vld_p1_q   <= 1'b0;
      rgb_p2_q   <= '0;
      hsync_p2_q <= 1'b1;
      vsync_p2_q <= 1'b1;
    end else begin
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      len_q      <= len_d;
      wbank_q    <= wbank_d;
      half_q     <= half_d;
      hs_prev_q  <= hs_prev_d;
      vld_p0_q   <= vld_p0_d;
      rcnt_p1_q  <= rcnt_p1_d;
      half_p1_q  <= half_p1_d;
      rsel_p1_q  <= rsel_p1_d;
      vld_p1_q   <= vld_p1_d;
      rgb_p2_q   <= rgb_p2_d;
      hsync_p2_q <= hsync_p2_d;
      vsync_p2_q <= vsync_p2_d;
    end
  end

  assign ro    = rgb_p2_q[8:6];
  assign go    = rgb_p2_q[5:3];
  assign bo    = rgb_p2_q[2:0];
  assign hsync = hsync_p2_q;
  assign vsync = vsync_p2_q;

endmodule

// File: tb/tb_vga_scandoubler.sv
// ----------------------------------------------------------------------------
// tb_vga_scandoubler
//
// Directed bench for vga_scandoubler. A stimulus process produces PAL lines
// (pixel value = address mod 8, or constant 7) with the hsync falling edge on
// the last pixel of each line; the main process checks output samples at
// fixed clk offsets after each input line start.
// ----------------------------------------------------------------------------
module tb_vga_scandoubler;

  logic       clk;
  logic       rst_n;
  logic       ce_pixel;
  logic       enable_scandoubling;
  logic       scanlines_enable;
  logic [2:0] ri, gi, bi;
  logic       hsync_ext_n;
  logic       vsync_ext_n;
  logic [2:0] ro, go, bo;
  logic       hsync;
  logic       vsync;

  vga_scandoubler dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ce_pixel            (ce_pixel),
    .enable_scandoubling (enable_scandoubling),
    .scanlines_enable    (scanlines_enable),
    .ri                  (ri),
    .gi                  (gi),
    .bi                  (bi),
    .hsync_ext_n         (hsync_ext_n),
    .vsync_ext_n         (vsync_ext_n),
    .ro                  (ro),
    .go                  (go),
    .bo                  (bo),
    .hsync               (hsync),
    .vsync               (vsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus controls (written by main process only)
  logic       gen_on = 1'b0;
  logic       val7 = 1'b0;
  int         line_pix = 448;
  logic       vs_in = 1'b1;
  logic [2:0] man_r = 3'd0, man_g = 3'd0, man_b = 3'd0;
  logic       man_hs = 1'b1;

  // Line start bookkeeping (written by generator only)
  int fall_c = 0;
  int fall_n = 0;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] rgb;
  assign rgb = {ro, go, bo};

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %o expected %o (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_fall();
    int n0;
    n0 = fall_n;
    for (int i = 0; i < 3000 && fall_n == n0; i++) @(negedge clk);
    chk("fall_seen", 9'(fall_n != n0), 9'd1);
  endtask

  // Advance to the negedge c clks after the latest input hsync falling edge.
  task automatic at_c(input int c);
    while (cyc < fall_c + c) @(negedge clk);
  endtask

  // Generator: inputs change 1 time unit after each posedge.
  initial begin
    int   a;
    logic ph;
    logic [2:0] v;
    a  = 31;
    ph = 1'b0;
    ce_pixel = 1'b0; ri = 3'd0; gi = 3'd0; bi = 3'd0;
    hsync_ext_n = 1'b1; vsync_ext_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      vsync_ext_n = vs_in;
      if (!gen_on) begin
        ce_pixel = 1'b0;
        ri = man_r; gi = man_g; bi = man_b;
        hsync_ext_n = man_hs;
      end else begin
        ph = ~ph;
        ce_pixel = ph;
        if (ph) begin
          v = val7 ? 3'd7 : a[2:0];
          ri = v; gi = v; bi = v;
          hsync_ext_n = !(a >= line_pix - 1 || a < 31);
          if (a >= line_pix - 1) begin
            fall_c = cyc + 1;
            fall_n++;
            a = 0;
          end else begin
            a++;
          end
        end
      end
    end
  end

  initial begin
    int lows;
    int bad;
    int n0;
    logic done;

    rst_n = 1'b0;
    enable_scandoubling = 1'b1;
    scanlines_enable = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rgb", rgb, 9'o000);
    chk("rst_hsync", 9'(hsync), 9'd1);
    chk("rst_vsync", 9'(vsync), 9'd1);
    rst_n = 1'b1;

    // No output hsync before any input line start
    lows = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!hsync || rgb != 9'o000) lows++;
    end
    chk("idle_no_hsync", 9'(lows), 9'd0);

    // Passthrough, latency 1 clk
    enable_scandoubling = 1'b0;
    man_r = 3'd5; man_g = 3'd2; man_b = 3'd7; man_hs = 1'b0; vs_in = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("pt_hs_before", 9'(hsync), 9'd1);
    chk("pt_rgb_before", rgb, 9'o000);
    @(posedge clk); @(negedge clk);
    chk("pt_rgb", rgb, 9'o527);
    chk("pt_hsync_lo", 9'(hsync), 9'd0);
    chk("pt_vsync_lo", 9'(vsync), 9'd0);
    man_hs = 1'b1; vs_in = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("pt_hs_hold", 9'(hsync), 9'd0);
    @(posedge clk); @(negedge clk);
    chk("pt_hsync_hi", 9'(hsync), 9'd1);
    chk("pt_vsync_hi", 9'(vsync), 9'd1);

    // 48K line: 448 pixels, hsync falling every 896 clk
    enable_scandoubling = 1'b1;
    gen_on = 1'b1;
    wait_fall();
    wait_fall();
    at_c(2);   chk("48k_c2_hs", 9'(hsync), 9'd0); chk("48k_c2_rgb", rgb, 9'o000);
    at_c(57);  chk("48k_c57_hs", 9'(hsync), 9'd0);
    at_c(58);  chk("48k_c58_hs", 9'(hsync), 9'd1); chk("48k_c58_rgb", rgb, 9'o000);
    at_c(62);  chk("48k_c62_rgb", rgb, 9'o444);
    at_c(449); chk("48k_c449_hs", 9'(hsync), 9'd1); chk("48k_c449_rgb", rgb, 9'o777);
    at_c(450); chk("48k_c450_hs", 9'(hsync), 9'd0);
    at_c(505); chk("48k_c505_hs", 9'(hsync), 9'd0);
    at_c(506); chk("48k_c506_hs", 9'(hsync), 9'd1);
    at_c(511); chk("48k_c511_rgb", rgb, 9'o555);

    // Scanlines on constant colour 7
    wait_fall();
    val7 = 1'b1;
    scanlines_enable = 1'b1;
    wait_fall();
    at_c(100); chk("scan_line1", rgb, 9'o777);
    at_c(548); chk("scan_line2", rgb, 9'o333);
    at_c(600); scanlines_enable = 1'b0;
    at_c(700); chk("noscan_line2", rgb, 9'o777);

    // 128K line: 456 pixels, len 455
    wait_fall();
    val7 = 1'b0;
    line_pix = 456;
    wait_fall();
    at_c(2);   chk("128k_c2_hs", 9'(hsync), 9'd0);
    at_c(58);  chk("128k_c58_hs", 9'(hsync), 9'd1); chk("128k_c58_rgb", rgb, 9'o000);
    at_c(457); chk("128k_c457_hs", 9'(hsync), 9'd1); chk("128k_c457_rgb", rgb, 9'o777);
    at_c(458); chk("128k_c458_hs", 9'(hsync), 9'd0);
    at_c(513); chk("128k_c513_hs", 9'(hsync), 9'd0);
    at_c(514); chk("128k_c514_hs", 9'(hsync), 9'd1);
    bad = 0;
    for (int l = 0; l < 15; l++) begin
      wait_fall();
      at_c(1);   if (hsync !== 1'b1) bad++;
      at_c(2);   if (hsync !== 1'b0) bad++;
      at_c(457); if (hsync !== 1'b1 || rgb !== 9'o777) bad++;
      at_c(458); if (hsync !== 1'b0) bad++;
    end
    chk("128k_drift", 9'(bad), 9'd0);

    // Overlong line: 650 pixels, write counter saturates, len 511
    wait_fall();
    line_pix = 650;
    wait_fall();
    at_c(102); chk("long_c102_rgb", rgb, 9'o444);
    at_c(513); chk("long_c513_hs", 9'(hsync), 9'd1); chk("long_c513_rgb", rgb, 9'o111);
    at_c(514); chk("long_c514_hs", 9'(hsync), 9'd0);
    at_c(574); chk("long_c574_hs", 9'(hsync), 9'd1); chk("long_c574_rgb", rgb, 9'o444);

    // Reset mid-line during active video
    line_pix = 448;
    vs_in = 1'b0;
    wait_fall();
    at_c(100);
    chk("pre_rst_rgb", rgb, 9'o222);
    chk("pre_rst_vsync", 9'(vsync), 9'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", rgb, 9'o000);
    chk("async_rst_hsync", 9'(hsync), 9'd1);
    chk("async_rst_vsync", 9'(vsync), 9'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = fall_n;
    lows = 0;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!hsync) lows++;
      if (fall_n != n0 && cyc >= fall_c + 1) done = 1'b1;
    end
    chk("post_rst_fall_seen", 9'(done), 9'd1);
    chk("post_rst_no_hsync", 9'(lows), 9'd0);
    at_c(2);  chk("post_rst_c2_hs", 9'(hsync), 9'd0);
    at_c(58); chk("post_rst_c58_hs", 9'(hsync), 9'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
